ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

Core-side PS/2 keyboard receiver: the far end of the I/O block's PS/2 keyboard transmitter. It deframes the 11-bit serial frames on `ps2_kbd_clk`/`ps2_kbd_data`, checks parity and framing, and tracks the E0/F0 prefixes. It emits one key event per make or break code to the core's keyboard matrix logic, with errors reported as single-cycle pulses.

## Interface
- `TIMEOUT_CYCLES`, 4096: `clk_sys` cycles without a PS/2 falling edge mid-frame before the frame is aborted. Range 64..65535.
- `clk_sys  in  1  system clock; all logic is clocked on its rising edge`
- `reset  in  1  synchronous, active-high reset`
- `ps2_kbd_clk  in  1  PS/2 clock line, idle high`
- `ps2_kbd_data  in  1  PS/2 data line, idle high`
- `rx_byte  out  8  last raw byte received with good parity and stop bit`
- `rx_strobe  out  1  one-cycle pulse; `rx_byte` is valid`
- `key_valid  out  1  one-cycle pulse; key event outputs are valid`
- `key_code  out  8  scancode without its prefixes`
- `key_extended  out  1  an E0 prefix preceded `key_code``
- `key_released  out  1  an F0 prefix preceded `key_code``
- `err_parity  out  1  one-cycle pulse on a parity failure`
- `err_frame  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout`

## Operation
- Input sync:
  - Both lines pass through a 2-flop synchronizer; a third flop on the clock line gives the previous value.
  - `fall` = prev & ~sync2.
  - Data is sampled from the data sync2 in the cycle `fall` is high.
- Frame FSM, one-hot or enum, states IDLE → DATA → PARITY → STOP → IDLE:
  - IDLE: on `fall`, if data=0, clear the bit counter and go to DATA. If data=1, pulse `err_frame` and stay in IDLE.
  - DATA: on each `fall`, shift the data bit into bit 7 and shift right (LSB first). After 8 bits, go to PARITY.
  - PARITY: on `fall`, latch the parity bit. Parity is good when the 8 data bits plus the parity bit hold an odd number of ones. Go to STOP.
  - STOP: on `fall`, evaluate in this order:
    - stop bit = 0 → `err_frame`;
    - else bad parity → `err_parity`;
    - else pulse `rx_strobe` and update `rx_byte`.
    - In every case go to IDLE.
- Prefix tracker:
  - Acts only on a good byte.
  - 0xE0 sets `ext_pend`; 0xF0 sets `rel_pend`; neither prefix produces `key_valid`.
  - Any other byte, including E1/AA/FA, produces `key_valid` with `key_code` = byte, `key_extended` = `ext_pend`, `key_released` = `rel_pend`, then clears both pend flags.
  - Any `err_parity` or `err_frame` clears both pend flags.
- Reset, including mid-frame:
  - FSM returns to IDLE; bit counter, shift register, pend flags and timeout counter are cleared.
  - All outputs go to 0.

## Timing
- Pin falling edge to `fall`: 3 cycles.
- Stop-bit pin edge to `rx_strobe`/`err_*`: 4 cycles.
- `key_valid` follows one cycle after the `rx_strobe` of the same byte.
- `key_code`/`key_extended`/`key_released` hold their values until the next `key_valid`. `rx_byte` holds until the next `rx_strobe`.
- At most one of `rx_strobe`, `err_parity`, `err_frame` is asserted in any cycle.
- Back-to-back frames with no idle gap are accepted: IDLE takes the next start bit on the first `fall`.
- Minimum PS/2 half-period: 4 `clk_sys` cycles. Behaviour with shorter half-periods is undefined.
- `reset` has priority over every event in the same cycle.

## Configuration
- `PS2_KBD_RX_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every `fall` and in IDLE, and increments in other states.
  - On reaching `TIMEOUT_CYCLES`: pulse `err_frame`, clear the pend flags, go to IDLE.
- Undefined: no counter. A stalled frame waits indefinitely for the next `fall`, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `ps2_pkg`:
  - frame state enum;
  - constants `PS2_PREFIX_EXT` = 8'hE0 and `PS2_PREFIX_REL` = 8'hF0;
  - `PS2_FRAME_BITS` = 11.
- Sub-module `ps2_rx_frame` holds the synchronizer, FSM, parity check and timeout, and drives `rx_byte`/`rx_strobe`/`err_*`.
- The top level adds the prefix tracker and the key event registers.

## Test plan
- Frame for 0x1C (parity 0, stop 1) at half-period 21 cycles → `rx_strobe` with `rx_byte`=0x1C, then `key_valid` with code 0x1C, ext=0, rel=0.
- Frames E0, F0, 75 → exactly one `key_valid`: code 0x75, ext=1, rel=1. The next frame 0x29 → code 0x29, ext=0, rel=0.
- Frame for 0x1C with parity 1 → `err_parity` 4 cycles after the stop edge, no `rx_strobe`, `rx_byte` unchanged.
- F0, then a frame with stop bit 0, then 0x1C → `err_frame`, then `key_valid` for 0x1C with rel=0 (pend flag cleared by the error).
- With `PS2_KBD_RX_TIMEOUT_EN`: stop the clock after 5 data bits for 4097 cycles → one `err_frame`, FSM in IDLE. A following 0x29 frame is received correctly.
- Assert `reset` for one cycle after bit 3 of a frame → all outputs 0. The remaining edges of the broken frame are ignored or flagged, and the next full frame 0x1C decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame deserializer: input sync, frame FSM, parity check and optional
// mid-frame timeout (enabled by defining PS2_KBD_RX_TIMEOUT_EN).
//
// state     | meaning
// ST_IDLE   | waiting for a start bit
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | waiting for the odd-parity bit
// ST_STOP   | waiting for the stop bit, then report byte or error
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  if (TIMEOUT_CYCLES < 64 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 64..65535");
  end

  logic         clk_s1, clk_s2, clk_prev;
  logic         dat_s1, dat_s2;
  logic         fall, bit_in;
  frame_state_t state;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift;
  logic         par_bit;
  logic         timeout;

  // Sync flops reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      fall     <= 1'b0;
      bit_in   <= 1'b0;
    end else begin
      clk_s1   <= ps2_kbd_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_kbd_data;
      dat_s2   <= dat_s1;
      fall     <= clk_prev & ~clk_s2;
      bit_in   <= dat_s2;
    end
  end

`ifdef PS2_KBD_RX_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_cnt;

  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_LIMIT);

  always_ff @(posedge clk_sys) begin
    if (reset || fall || state == ST_IDLE) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      rx_byte    <= '0;
      rx_strobe  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      rx_strobe  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (timeout) begin
        err_frame <= 1'b1;
        state     <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!bit_in) begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end else begin
              err_frame <= 1'b1;
            end
          end
          ST_DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= bit_in;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            // Framing outranks parity: a bad stop bit means the byte is suspect anyway.
            if (!bit_in)                  err_frame  <= 1'b1;
            else if (!(^{shift, par_bit})) err_parity <= 1'b1;
            else begin
              rx_strobe <= 1'b1;
              rx_byte   <= shift;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: frame deserializer plus E0/F0 prefix tracking.
// Optional mid-frame timeout is enabled by defining PS2_KBD_RX_TIMEOUT_EN.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       err_parity,
  output logic       err_frame
);

  logic ext_pend, rel_pend;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .err_parity  (err_parity),
    .err_frame   (err_frame)
  );

  // Any error discards a half-received prefix sequence.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_pend     <= 1'b0;
      rel_pend     <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (err_parity || err_frame) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (rx_strobe) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_REL) begin
          rel_pend <= 1'b1;
        end else begin
          key_valid    <= 1'b1;
          key_code     <= rx_byte;
          key_extended <= ext_pend;
          key_released <= rel_pend;
          ext_pend     <= 1'b0;
          rel_pend     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: table of frames plus reset/stall sequences.
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int HALF = 21;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_kbd_clk = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic       rx_strobe, key_valid, key_extended, key_released, err_parity, err_frame;

  ps2_kbd_rx #(.TIMEOUT_CYCLES(4096)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_released(key_released),
    .err_parity  (err_parity),
    .err_frame   (err_frame)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] data;
    bit         par_ok;
    bit         stop;
    int         exp_strobe;
    int         exp_perr;
    int         exp_ferr;
    int         exp_kv;
    logic [7:0] exp_rx;
    logic [7:0] exp_code;
    bit         exp_ext;
    bit         exp_rel;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c_stop = 0;
  int n_strobe, n_perr, n_ferr, n_kv, n_overlap = 0;
  int cyc_strobe, cyc_perr, cyc_ferr, cyc_kv;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    cyc++;
    if (rx_strobe) begin n_strobe++; cyc_strobe = cyc; end
    if (err_parity) begin n_perr++; cyc_perr = cyc; end
    if (err_frame) begin n_ferr++; cyc_ferr = cyc; end
    if (key_valid) begin n_kv++; cyc_kv = cyc; end
    if (int'(rx_strobe) + int'(err_parity) + int'(err_frame) > 1) n_overlap++;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    n_strobe = 0; n_perr = 0; n_ferr = 0; n_kv = 0;
    cyc_strobe = -100; cyc_perr = -100; cyc_ferr = -100; cyc_kv = -100;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par_ok, input bit stop);
    logic p;
    p = par_ok ? ~^d : ^d;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_kbd_data = b[i];
      wait_ticks(HALF);
      ps2_kbd_clk = 1'b0;
      if (i == PS2_FRAME_BITS - 1) c_stop = cyc;
      wait_ticks(HALF);
      ps2_kbd_clk = 1'b1;
    end
  endtask

  vec_t vecs[15];

  initial begin
    logic [10:0] fb;
    vecs[0]  = '{8'h1C, 1, 1, 1, 0, 0, 1, 8'h1C, 8'h1C, 0, 0};
    vecs[1]  = '{8'hE0, 1, 1, 1, 0, 0, 0, 8'hE0, 8'h1C, 0, 0};
    vecs[2]  = '{8'hF0, 1, 1, 1, 0, 0, 0, 8'hF0, 8'h1C, 0, 0};
    vecs[3]  = '{8'h75, 1, 1, 1, 0, 0, 1, 8'h75, 8'h75, 1, 1};
    vecs[4]  = '{8'h29, 1, 1, 1, 0, 0, 1, 8'h29, 8'h29, 0, 0};
    vecs[5]  = '{8'h1C, 0, 1, 0, 1, 0, 0, 8'h29, 8'h29, 0, 0};
    vecs[6]  = '{8'hF0, 1, 1, 1, 0, 0, 0, 8'hF0, 8'h29, 0, 0};
    vecs[7]  = '{8'h1C, 1, 0, 0, 0, 1, 0, 8'hF0, 8'h29, 0, 0};
    vecs[8]  = '{8'h1C, 1, 1, 1, 0, 0, 1, 8'h1C, 8'h1C, 0, 0};
    vecs[9]  = '{8'hE0, 1, 1, 1, 0, 0, 0, 8'hE0, 8'h1C, 0, 0};
    vecs[10] = '{8'h5A, 1, 1, 1, 0, 0, 1, 8'h5A, 8'h5A, 1, 0};
    vecs[11] = '{8'hF0, 1, 1, 1, 0, 0, 0, 8'hF0, 8'h5A, 1, 0};
    vecs[12] = '{8'hAA, 1, 1, 1, 0, 0, 1, 8'hAA, 8'hAA, 0, 1};
    vecs[13] = '{8'hE1, 1, 1, 1, 0, 0, 1, 8'hE1, 8'hE1, 0, 0};
    vecs[14] = '{8'h1C, 0, 0, 0, 0, 1, 0, 8'hE1, 8'hE1, 0, 0};

    clear_mon();
    wait_ticks(3);
    reset = 1'b0;
    wait_ticks(2);
    chk("reset rx_byte", rx_byte, 0);
    chk("reset key_code", key_code, 0);
    chk("reset key_ext", key_extended, 0);
    chk("reset key_rel", key_released, 0);
    chk("reset pulses", n_strobe + n_perr + n_ferr + n_kv, 0);

    for (int v = 0; v < 15; v++) begin
      clear_mon();
      send_bits(frame_bits(vecs[v].data, vecs[v].par_ok, vecs[v].stop), 0, 10);
      wait_ticks(10);
      chk($sformatf("v%0d rx_strobe count", v), n_strobe, vecs[v].exp_strobe);
      chk($sformatf("v%0d err_parity count", v), n_perr, vecs[v].exp_perr);
      chk($sformatf("v%0d err_frame count", v), n_ferr, vecs[v].exp_ferr);
      chk($sformatf("v%0d key_valid count", v), n_kv, vecs[v].exp_kv);
      chk($sformatf("v%0d rx_byte", v), rx_byte, vecs[v].exp_rx);
      chk($sformatf("v%0d key_code", v), key_code, vecs[v].exp_code);
      chk($sformatf("v%0d key_extended", v), key_extended, vecs[v].exp_ext);
      chk($sformatf("v%0d key_released", v), key_released, vecs[v].exp_rel);
      if (vecs[v].exp_strobe == 1)
        chk($sformatf("v%0d strobe latency", v), cyc_strobe - c_stop, 4);
      if (vecs[v].exp_perr == 1)
        chk($sformatf("v%0d err_parity latency", v), cyc_perr - c_stop, 4);
      if (vecs[v].exp_ferr == 1)
        chk($sformatf("v%0d err_frame latency", v), cyc_ferr - c_stop, 4);
      if (vecs[v].exp_kv == 1)
        chk($sformatf("v%0d key_valid after strobe", v), cyc_kv - cyc_strobe, 1);
    end

    // Reset after data bit 3, then drain the broken frame with idle-high bits.
    clear_mon();
    fb = frame_bits(8'h1C, 1, 1);
    send_bits(fb, 0, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("midreset rx_byte", rx_byte, 0);
    chk("midreset key_code", key_code, 0);
    chk("midreset pulses", int'(rx_strobe) + int'(key_valid) + int'(err_parity) + int'(err_frame), 0);
    send_bits(fb, 5, 10);
    send_bits(11'h7FF, 0, 10);
    clear_mon();
    send_bits(fb, 0, 10);
    wait_ticks(10);
    chk("post-reset strobe", n_strobe, 1);
    chk("post-reset err", n_perr + n_ferr, 0);
    chk("post-reset key_valid", n_kv, 1);
    chk("post-reset key_code", key_code, 8'h1C);
    chk("post-reset ext/rel", {key_extended, key_released}, 0);

    // Clock stalls high after 5 data bits.
    clear_mon();
    fb = frame_bits(8'h29, 1, 1);
    send_bits(fb, 0, 5);
    wait_ticks(4097);
`ifdef PS2_KBD_RX_TIMEOUT_EN
    chk("stall err_frame", n_ferr, 1);
    chk("stall strobe", n_strobe, 0);
    clear_mon();
    send_bits(fb, 0, 10);
`else
    chk("stall err_frame", n_ferr, 0);
    chk("stall strobe", n_strobe, 0);
    send_bits(fb, 6, 10);
`endif
    wait_ticks(10);
    chk("after stall strobe", n_strobe, 1);
    chk("after stall rx_byte", rx_byte, 8'h29);
    chk("after stall key_valid", n_kv, 1);
    chk("after stall key_code", key_code, 8'h29);
    chk("after stall ext/rel", {key_extended, key_released}, 0);

    chk("pulse exclusivity", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
